// File: rtl/aes_pkg.sv
// Shared AES constants, state-machine encoding and parameter helpers.
// Imported by the inverse-SubBytes datapath and its S-box lookup.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_BYTES   = AES_STATE_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 16);
    endfunction

    // Lane-group counter width; a single group still gets one bit.
    function automatic int cnt_width(input int lanes);
        int groups;
        groups = AES_BYTES / lanes;
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// FIPS-197 inverse S-box, purely combinational byte lookup.
// Ports: i_Byte (8-bit in), o_Byte (8-bit substituted out).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] i_Byte,
    output logic [AES_BYTE_W-1:0] o_Byte
);

    localparam logic [AES_BYTE_W-1:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_Byte = INV_SBOX[i_Byte];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: LANES bytes substituted per cycle in place.
// Ports: i_Clk/i_Rst, i_Valid/o_Ready + i_Din in, o_Valid/i_Ready + o_Dout out, o_Busy.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [AES_STATE_W-1:0] i_Din,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [AES_STATE_W-1:0] o_Dout,
    output logic                   o_Busy
);

    localparam int GROUPS = AES_BYTES / LANES;
    localparam int CNT_W  = cnt_width(LANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4 or 16");
    end

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AES_BYTES-1:0][AES_BYTE_W-1:0] work_q, work_d;
    logic ready_q, ready_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;

    logic [3:0] grp_base;
    logic [LANES-1:0][AES_BYTE_W-1:0] sb_in;
    logic [LANES-1:0][AES_BYTE_W-1:0] sb_out;

    // First byte of the group addressed by the lane counter.
    always_comb begin
        grp_base = 4'(int'(cnt_q) * LANES);
        for (int l = 0; l < LANES; l++) begin
            sb_in[l] = work_q[grp_base + 4'(l)];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_inv_sbox u_sbox (
            .i_Byte (sb_in[l]),
            .o_Byte (sb_out[l])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (i_Valid) begin
                    work_d  = i_Din;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[grp_base + 4'(l)] = sb_out[l];
                end
                // Counter parks on the last group; only acceptance rewinds it.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (i_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next state.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
        busy_d  = (state_d == RUN);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Ready = ready_q;
    assign o_Valid = valid_q;
    assign o_Busy  = busy_q;
    assign o_Dout  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter at LANES = 4, 1 and 16.
// Reference inverse S-box is derived from GF(2^8) inversion plus the affine map.
module tb_inv_sub_bytes_iter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst;
    logic [N-1:0] vin;
    logic [N-1:0] rdy_in;
    logic [N-1:0] rdy_o;
    logic [N-1:0] vld_o;
    logic [N-1:0] busy_o;
    logic [N-1:0][127:0] din;
    logic [N-1:0][127:0] dout;

    // Instance 0: LANES=4, instance 1: LANES=1, instance 2: LANES=16.
    for (genvar g = 0; g < N; g++) begin : g_dut
        inv_sub_bytes_iter #(
            .LANES (g == 0 ? 4 : (g == 1 ? 1 : 16))
        ) u_dut (
            .i_Clk   (clk),
            .i_Rst   (rst[g]),
            .i_Valid (vin[g]),
            .o_Ready (rdy_o[g]),
            .i_Din   (din[g]),
            .o_Valid (vld_o[g]),
            .i_Ready (rdy_in[g]),
            .o_Dout  (dout[g]),
            .o_Busy  (busy_o[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] ref_inv [256];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box = affine(GF inverse); the reference is its inverse map.
    task automatic build_model();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                ^ rotl(inv, 4) ^ 8'h63;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_word(input logic [127:0] w);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_inv[w[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_all();
        rst    = '1;
        vin    = '0;
        rdy_in = '0;
        din    = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst%0d_dout", i), dout[i], '0);
            chk($sformatf("rst%0d_valid", i), 128'(vld_o[i]), 128'(0));
            chk($sformatf("rst%0d_busy", i), 128'(busy_o[i]), 128'(0));
            chk($sformatf("rst%0d_ready", i), 128'(rdy_o[i]), 128'(1));
        end
        rst = '0;
    endtask

    // Offer one word for a single cycle, check latency and result, release.
    task automatic run_word(input int idx, input int lat,
                            input logic [127:0] w, input string tag);
        logic [127:0] exp;
        exp = ref_word(w);
        din[idx]    = w;
        vin[idx]    = 1'b1;
        rdy_in[idx] = 1'b0;
        @(negedge clk);
        vin[idx] = 1'b0;
        din[idx] = rnd128();
        chk({tag, "_ready_lo"}, 128'(rdy_o[idx]), 128'(0));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == lat) begin
                chk({tag, "_valid_at_lat"}, 128'(vld_o[idx]), 128'(1));
            end else if (vld_o[idx] !== 1'b0) begin
                chk({tag, "_valid_early"}, 128'(vld_o[idx]), 128'(0));
            end
        end
        chk({tag, "_dout"}, dout[idx], exp);
        rdy_in[idx] = 1'b1;
        @(negedge clk);
        rdy_in[idx] = 1'b0;
        chk({tag, "_valid_drop"}, 128'(vld_o[idx]), 128'(0));
        chk({tag, "_ready_back"}, 128'(rdy_o[idx]), 128'(1));
    endtask

    initial begin
        logic [127:0] w, exp, held;
        logic seen;
        int p;
        int cyc_q[$];
        logic [127:0] res_q[$];
        logic [127:0] words [2];
        int gap;

        rst    = '1;
        vin    = '0;
        rdy_in = '0;
        din    = '0;
        build_model();
        @(negedge clk);
        reset_all();

        // Known vectors at LANES = 4
        run_word(0, 4, {16{8'h63}}, "l4_63");
        chk("l4_63_const", dout[0], '0);
        run_word(0, 4, '0, "l4_zero");
        chk("l4_zero_const", dout[0], {16{8'h52}});
        run_word(0, 4, {16{8'h16}}, "l4_16");
        chk("l4_16_const", dout[0], {16{8'hff}});
        w = rnd128();
        w[47:40] = 8'h7c;
        run_word(0, 4, w, "l4_7c");
        held = dout[0];
        chk("l4_7c_byte", 128'(held[47:40]), 128'(8'h01));
        for (int i = 0; i < 6; i++) begin
            run_word(0, 4, rnd128(), $sformatf("l4_rnd%0d", i));
        end

        // Backpressure with upstream noise while DONE
        w = rnd128();
        exp = ref_word(w);
        din[0] = w;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            din[0] = rnd128();
            vin[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk($sformatf("bp%0d_dout", i), dout[0], exp);
            chk($sformatf("bp%0d_valid", i), 128'(vld_o[0]), 128'(1));
            chk($sformatf("bp%0d_ready", i), 128'(rdy_o[0]), 128'(0));
        end
        vin[0] = 1'b0;
        rdy_in[0] = 1'b1;
        @(negedge clk);
        rdy_in[0] = 1'b0;
        chk("bp_release_ready", 128'(rdy_o[0]), 128'(1));

        // Reset during the second RUN cycle
        din[0] = rnd128();
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rdy_in[0] = 1'b1;
        chk("midrst_dout", dout[0], '0);
        chk("midrst_ready", 128'(rdy_o[0]), 128'(1));
        chk("midrst_busy", 128'(busy_o[0]), 128'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vld_o[0] !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_valid", 128'(seen), 128'(0));

        // Back-to-back, two words offered continuously, sink always ready
        words[0] = rnd128();
        words[1] = rnd128();
        rdy_in[0] = 1'b1;
        p = 0;
        for (int c = 0; c < 40; c++) begin
            if (vld_o[0] === 1'b1) begin
                cyc_q.push_back(c);
                res_q.push_back(dout[0]);
            end
            if (p < 2) begin
                din[0] = words[p];
                vin[0] = 1'b1;
                if (rdy_o[0] === 1'b1) p++;
            end else begin
                vin[0] = 1'b0;
            end
            @(negedge clk);
        end
        rdy_in[0] = 1'b0;
        chk("b2b_count", 128'(cyc_q.size()), 128'(2));
        gap = (cyc_q.size() >= 2) ? cyc_q[1] - cyc_q[0] : -1;
        chk("b2b_gap", 128'(gap), 128'(6));
        chk("b2b_res0", (res_q.size() >= 1) ? res_q[0] : 'x,
            ref_word(words[0]));
        chk("b2b_res1", (res_q.size() >= 2) ? res_q[1] : 'x,
            ref_word(words[1]));

        // Latency at the other lane widths
        run_word(1, 16, {16{8'h63}}, "l1_63");
        chk("l1_63_const", dout[1], '0);
        run_word(1, 16, rnd128(), "l1_rnd");
        run_word(2, 1, {16{8'h63}}, "l16_63");
        chk("l16_63_const", dout[2], '0);
        run_word(2, 1, rnd128(), "l16_rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
